// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Define MC_ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state with illegal_op.
module multicycle_control #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsource,
  output logic       aluop2,
  output logic       aluop1,
  output logic       aluop0,
  output logic       mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_t;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_t            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q;
  logic              mem_state, waiting;
  logic [2:0]        aluop;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign waiting   = mem_state && !mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw:            state_d = StMemAdr;
          OpR:                   state_d = StRExec;
          OpBeq:                 state_d = StBranch;
          OpAddi, OpAndi, OpOri: state_d = StIExec;
          OpJ:                   state_d = StJump;
`ifdef MC_ILLEGAL_TRAP_EN
          default:               state_d = StTrap;
`else
          default:               state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StRExec:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // Wait counter saturates at WAIT_MAX; the timeout flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (waiting && (32'(wait_cnt_q) < WAIT_MAX)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if ((WAIT_MAX > 0) && waiting && (32'(wait_cnt_q) + 32'd1 >= WAIT_MAX)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Decoded from state_q; FETCH's IR/PC load is additionally qualified by the ready cycle.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    extop       = 1'b1;
    pcsource    = 2'b00;
    aluop       = 3'b000;
    unique case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StRExec: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
      end
      StRWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBranch: begin
        alusrca     = 1'b1;
        aluop       = 3'b001;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      StIExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OpAndi: begin
            aluop = 3'b101;
            extop = 1'b0;
          end
          OpOri: begin
            aluop = 3'b100;
            extop = 1'b0;
          end
          default: aluop = 3'b000;
        endcase
      end
      StIWb:  regwrite = 1'b1;
      StJump: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      default: ;
    endcase
  end

  assign {aluop2, aluop1, aluop0} = aluop;
  assign state = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; a second instance runs with WAIT_MAX=2.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite;
  logic       alusrca, extop, aluop2, aluop1, aluop0, mem_timeout;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic       b_pcwrite, b_pcwritecond, b_iord, b_memread, b_memwrite, b_irwrite, b_memtoreg;
  logic       b_regdst, b_regwrite, b_alusrca, b_extop, b_aluop2, b_aluop1, b_aluop0;
  logic       b_mem_timeout;
  logic [1:0] b_alusrcb, b_pcsource;
  logic [3:0] b_state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op, b_illegal_op;
`endif
  logic [17:0] ctl;

  int total = 0;
  int passed = 0;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,
  //  alusrcb,extop,pcsource,aluop}
  localparam logic [17:0] CFetchW = 18'b0_0_0_1_0_0_0_0_0_0_01_1_00_000;
  localparam logic [17:0] CFetchR = 18'b1_0_0_1_0_1_0_0_0_0_01_1_00_000;
  localparam logic [17:0] CDec    = 18'b0_0_0_0_0_0_0_0_0_0_11_1_00_000;
  localparam logic [17:0] CMAdr   = 18'b0_0_0_0_0_0_0_0_0_1_10_1_00_000;
  localparam logic [17:0] CMRd    = 18'b0_0_1_1_0_0_0_0_0_0_00_1_00_000;
  localparam logic [17:0] CMWb    = 18'b0_0_0_0_0_0_1_0_1_0_00_1_00_000;
  localparam logic [17:0] CMWr    = 18'b0_0_1_0_1_0_0_0_0_0_00_1_00_000;
  localparam logic [17:0] CRExec  = 18'b0_0_0_0_0_0_0_0_0_1_00_1_00_010;
  localparam logic [17:0] CRWb    = 18'b0_0_0_0_0_0_0_1_1_0_00_1_00_000;
  localparam logic [17:0] CBr     = 18'b0_1_0_0_0_0_0_0_0_1_00_1_01_001;
  localparam logic [17:0] CAddi   = 18'b0_0_0_0_0_0_0_0_0_1_10_1_00_000;
  localparam logic [17:0] CAndi   = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_101;
  localparam logic [17:0] COri    = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_100;
  localparam logic [17:0] CIWb    = 18'b0_0_0_0_0_0_0_0_1_0_00_1_00_000;
  localparam logic [17:0] CJump   = 18'b1_0_0_0_0_0_0_0_0_0_00_1_10_000;
  localparam logic [17:0] CIdle   = 18'b0_0_0_0_0_0_0_0_0_0_00_1_00_000;

  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, extop, pcsource, aluop2, aluop1, aluop0};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop),
    .pcsource(pcsource), .aluop2(aluop2), .aluop1(aluop1), .aluop0(aluop0),
    .mem_timeout(mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  multicycle_control #(.WAIT_MAX(2)) dut_short (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond), .iord(b_iord), .memread(b_memread),
    .memwrite(b_memwrite), .irwrite(b_irwrite), .memtoreg(b_memtoreg), .regdst(b_regdst),
    .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb), .extop(b_extop),
    .pcsource(b_pcsource), .aluop2(b_aluop2), .aluop1(b_aluop1), .aluop0(b_aluop0),
    .mem_timeout(b_mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op(b_illegal_op),
`endif
    .state(b_state)
  );

  // Leaves the DUTs in FETCH at 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b000000; mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd0 || ctl !== CFetchW || mem_timeout !== 1'b0 || b_mem_timeout !== 1'b0)
      $display("FAIL reset: state=%0d ctl=%b to=%b/%b, want 0 %b 0/0",
               state, ctl, mem_timeout, b_mem_timeout, CFetchW);
    else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd0 || ctl !== CFetchW)
      $display("FAIL reset_hold: state=%0d ctl=%b, want 0 %b", state, ctl, CFetchW);
    else passed++;
  endtask

  task automatic test_lw();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [17:0] ec [6] = '{CFetchR, CDec, CMAdr, CMRd, CMWb, CFetchR};
    do_reset(); op = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1 total++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL lw cyc%0d: state=%0d ctl=%b, want %0d %b", i, state, ctl, es[i], ec[i]);
      else passed++;
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [17:0] ec [5] = '{CFetchR, CDec, CMAdr, CMWr, CFetchR};
    do_reset(); op = 6'b101011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1 total++;
      if (state !== es[i] || ctl !== ec[i])
        $display("FAIL sw cyc%0d: state=%0d ctl=%b, want %0d %b", i, state, ctl, es[i], ec[i]);
      else passed++;
    end
  endtask

  // One 4-cycle (or 3-cycle) instruction per row: op, execute state/ctl, writeback state/ctl.
  task automatic test_alu_ops();
    logic [5:0]  ops [6] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b000100, 6'b000010};
    logic [3:0]  ex  [6] = '{4'd6, 4'd9, 4'd9, 4'd9, 4'd8, 4'd11};
    logic [17:0] exc [6] = '{CRExec, CAddi, CAndi, COri, CBr, CJump};
    logic [3:0]  wb  [6] = '{4'd7, 4'd10, 4'd10, 4'd10, 4'd0, 4'd0};
    logic [17:0] wbc [6] = '{CRWb, CIWb, CIWb, CIWb, CFetchR, CFetchR};
    for (int i = 0; i < 6; i++) begin
      do_reset(); op = ops[i]; mem_ready = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      total++;
      if (state !== ex[i] || ctl !== exc[i])
        $display("FAIL exec op=%b: state=%0d ctl=%b, want %0d %b", ops[i], state, ctl, ex[i], exc[i]);
      else passed++;
      @(posedge clk); #2;
      total++;
      if (state !== wb[i] || ctl !== wbc[i])
        $display("FAIL wb op=%b: state=%0d ctl=%b, want %0d %b", ops[i], state, ctl, wb[i], wbc[i]);
      else passed++;
    end
  endtask

  task automatic test_fetch_wait();
    do_reset(); op = 6'b100011; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 total++;
      if (state !== 4'd0 || ctl !== CFetchW)
        $display("FAIL fetch_wait cyc%0d: state=%0d ctl=%b, want 0 %b", i, state, ctl, CFetchW);
      else passed++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1 total++;
    if (state !== 4'd0 || ctl !== CFetchR)
      $display("FAIL fetch_ready: state=%0d ctl=%b, want 0 %b", state, ctl, CFetchR);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd1 || mem_timeout !== 1'b0)
      $display("FAIL fetch_done: state=%0d to=%b, want 1 0", state, mem_timeout);
    else passed++;
  endtask

  task automatic test_wait_timeout();
    do_reset(); op = 6'b100011; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 total++;
      if (b_state !== 4'd3 || b_mem_timeout !== (i >= 2) || mem_timeout !== 1'b0)
        $display("FAIL timeout wait%0d: state=%0d to2=%b to15=%b, want 3 %b 0",
                 i + 1, b_state, b_mem_timeout, mem_timeout, (i >= 2));
      else passed++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (b_state !== 4'd4 || b_mem_timeout !== 1'b1)
      $display("FAIL timeout_sticky: state=%0d to2=%b, want 4 1", b_state, b_mem_timeout);
    else passed++;
    do_reset();
    #1 total++;
    if (b_mem_timeout !== 1'b0 || b_state !== 4'd0)
      $display("FAIL timeout_clear: state=%0d to2=%b, want 0 0", b_state, b_mem_timeout);
    else passed++;
  endtask

  task automatic test_reset_mid_memwr();
    do_reset(); op = 6'b101011; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd5 || ctl !== CMWr)
      $display("FAIL memwr_hold: state=%0d ctl=%b, want 5 %b", state, ctl, CMWr);
    else passed++;
    #2 reset = 1'b1;
    #1 total++;
    if (state !== 4'd0 || memwrite !== 1'b0 || ctl !== CFetchW)
      $display("FAIL async_reset: state=%0d memwrite=%b ctl=%b, want 0 0 %b",
               state, memwrite, ctl, CFetchW);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 total++;
      if (state !== 4'd0 || regwrite !== 1'b0 || pcwrite !== 1'b0 || memwrite !== 1'b0)
        $display("FAIL post_reset cyc%0d: state=%0d rw=%b pw=%b mw=%b, want 0 0 0 0",
                 i, state, regwrite, pcwrite, memwrite);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_unknown_op();
`ifdef MC_ILLEGAL_TRAP_EN
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd12, 4'd12, 4'd12};
    logic [17:0] ec [5] = '{CFetchR, CDec, CIdle, CIdle, CIdle};
    logic        ei [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    logic [17:0] ec [5] = '{CFetchR, CDec, CFetchR, CDec, CFetchR};
    logic        ei [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    logic        il;
    do_reset(); op = 6'b111111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
`ifdef MC_ILLEGAL_TRAP_EN
      il = illegal_op;
`else
      il = 1'b0;
`endif
      #1 total++;
      if (state !== es[i] || ctl !== ec[i] || il !== ei[i])
        $display("FAIL unknown_op cyc%0d: state=%0d ctl=%b ill=%b, want %0d %b %b",
                 i, state, ctl, il, es[i], ec[i], ei[i]);
      else passed++;
    end
    do_reset();
    #1 total++;
    if (state !== 4'd0)
      $display("FAIL unknown_op_reset: state=%0d, want 0", state);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_fetch_wait();
    test_wait_timeout();
    test_reset_mid_memwr();
    test_unknown_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
